mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset (asserted when rst=1).
REQ-002 SHALL have EX/MEM-side inputs: mem_wd in 5, dest reg; mem_wreg in 1, write enable; mem_wdata in 32, ALU result; mem_aluop in 8, op code; mem_mem_addr in 32, effective address; mem_reg2 in 32, store data.
REQ-003 SHALL have MEM/WB-side outputs: wb_wd out 5; wb_wreg out 1; wb_wdata out 32; stallreq out 1, pipeline stall request; align_exc out 1, misalignment flag.
REQ-004 SHALL have data-bus ports: dbus_req out 1; dbus_we out 1; dbus_addr out 32; dbus_sel out 4, byte lanes; dbus_wdata out 32; dbus_rdata in 32; dbus_ack in 1.

Function
REQ-005 SHALL treat LB, LBU, LH, LHU, LW, SB, SH, SW aluops as memory ops; all other aluops pass through with zero stall.
REQ-006 SHALL implement FSM IDLE, BUSY, DONE.
REQ-007 IDLE + memory op: stallreq=1 combinationally; next edge registers addr/sel/we/wdata, sets dbus_req=1, enters BUSY.
REQ-008 BUSY: stallreq=1; dbus_req and all bus outputs held stable until dbus_ack sampled 1; on that edge capture extended load data, drop dbus_req, enter DONE.
REQ-009 DONE: stallreq=0; no new request; unconditionally return to IDLE next edge (held instruction is not re-issued).
REQ-010 Minimum memory-op latency SHALL be 3 cycles (ack in first BUSY cycle); each extra ack-wait cycle adds one.
REQ-011 Byte order SHALL be big-endian: addr[1:0]=00 -> dbus_sel 1000, 11 -> 0001; halfword addr[1]=0 -> 1100, 1 -> 0011; word -> 1111.
REQ-012 Stores SHALL replicate mem_reg2 low byte/halfword onto all lanes of dbus_wdata; dbus_we=1 stores, 0 loads.
REQ-013 Loads SHALL select the addressed lane; LB/LH sign-extend, LBU/LHU zero-extend, to 32 bits.
REQ-014 wb_wd, wb_wreg SHALL pass through combinationally; wb_wdata = captured load data for loads, mem_wdata otherwise.
REQ-015 dbus_ack outside BUSY SHALL be ignored.
REQ-016 dbus_addr SHALL be mem_mem_addr with bits[1:0] forced 00.

Reset
REQ-017 Asserting rst at any time, including mid-BUSY, SHALL immediately set state IDLE, dbus_req=0, dbus_we=0, dbus_addr=0, dbus_sel=0, dbus_wdata=0, load-data register=0.
REQ-018 During reset stallreq=0 and align_exc=0; wb_* follow inputs per REQ-014.

Configuration
REQ-019 Macro MEM_ALIGN_CHK_EN SHALL, when defined, flag LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=00: align_exc=1 combinationally, wb_wreg=0, no bus request, no stall.
REQ-020 Without MEM_ALIGN_CHK_EN, align_exc SHALL be tied 0 and misaligned low bits ignored (halfword uses addr[1], word uses 1111).

Structure
REQ-021 Aluop codes, RegBus/RegAddrBus/AluOpBus widths, ZeroWord SHALL come from the shared defines file; FSM state encodings belong there too.
REQ-022 Lane-select and load-extension logic SHALL be one sub-module mem_lane_align (combinational); FSM stays in top.

Verification
REQ-023 LW addr 0x0000_0010, ack in first BUSY cycle, rdata 0xDEADBEEF -> dbus_sel 1111, stallreq high 2 cycles, wb_wdata 0xDEADBEEF in DONE.
REQ-024 LB addr 0x0000_0003, rdata 0x000000F0 -> sel 0001, wb_wdata 0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-025 SH addr 0x0000_0002, reg2 0x1234ABCD, ack after 3 wait cycles -> sel 0011, wdata 0xABCDABCD, we=1, stallreq high 5 cycles.
REQ-026 ADD op with wdata 0x5 -> no dbus_req, stallreq=0, wb_wdata 0x5 same cycle.
REQ-027 rst pulsed during BUSY before ack -> dbus_req=0 immediately, state IDLE; later ack ignored.
REQ-028 With MEM_ALIGN_CHK_EN, LW addr 0x0000_0006 -> align_exc=1, wb_wreg=0, no dbus_req; without macro -> normal word access at 0x0000_0004.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory-stage bus controller: bus widths, aluop codes,
// FSM state encoding and op-class helpers.
package mem_bus_ctrl_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'h00;
  localparam logic [AluOpBus-1:0] EXE_ADD_OP = 8'h20;
  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'he0;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'he1;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'he3;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'he4;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'he5;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'he8;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'he9;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'heb;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  function automatic logic is_load_op(input logic [AluOpBus-1:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load_op = 1'b1;
      default: is_load_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [AluOpBus-1:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_mem_op = 1'b1;
      default: is_mem_op = is_load_op(op);
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_lane_align.sv
// mem_lane_align: big-endian byte-lane select, store replication and load extension.
// Purely combinational; the controller registers whatever it needs.
module mem_lane_align
  import mem_bus_ctrl_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop,
  input  logic [1:0]          addr_lo,
  input  logic [RegBus-1:0]   reg2,
  input  logic [RegBus-1:0]   rdata,
  output logic [3:0]          sel,
  output logic [RegBus-1:0]   wdata,
  output logic [RegBus-1:0]   load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = 8'h00;
    case (addr_lo)
      2'b00: rd_byte = rdata[31:24];
      2'b01: rd_byte = rdata[23:16];
      2'b10: rd_byte = rdata[15:8];
      2'b11: rd_byte = rdata[7:0];
      default: ;
    endcase
    rd_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    sel       = 4'b0000;
    wdata     = reg2;
    load_data = ZeroWord;
    case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sel = 4'b1000 >> addr_lo;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sel = addr_lo[1] ? 4'b0011 : 4'b1100;
      EXE_LW_OP, EXE_SW_OP:             sel = 4'b1111;
      default: ;
    endcase
    case (aluop)
      EXE_SB_OP:  wdata     = {4{reg2[7:0]}};
      EXE_SH_OP:  wdata     = {2{reg2[15:0]}};
      EXE_LB_OP:  load_data = {{24{rd_byte[7]}}, rd_byte};
      EXE_LBU_OP: load_data = {24'h000000, rd_byte};
      EXE_LH_OP:  load_data = {{16{rd_half[15]}}, rd_half};
      EXE_LHU_OP: load_data = {16'h0000, rd_half};
      EXE_LW_OP:  load_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-stage data-bus controller: stalls the pipeline around one bus transaction per
// load/store. Optional misalignment trap enabled by defining MEM_ALIGN_CHK_EN.
//
// state | meaning
// IDLE  | no transaction; a memory op stalls and launches the request
// BUSY  | request outstanding, bus outputs frozen until dbus_ack
// DONE  | result available, stall released, back to IDLE next edge
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [RegBus-1:0]     mem_wdata,
  input  logic [AluOpBus-1:0]   mem_aluop,
  input  logic [RegBus-1:0]     mem_mem_addr,
  input  logic [RegBus-1:0]     mem_reg2,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [RegBus-1:0]     wb_wdata,
  output logic                  stallreq,
  output logic                  align_exc,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [RegBus-1:0]     dbus_addr,
  output logic [3:0]            dbus_sel,
  output logic [RegBus-1:0]     dbus_wdata,
  input  logic [RegBus-1:0]     dbus_rdata,
  input  logic                  dbus_ack
);

  mem_state_t        state, state_nxt;
  logic              mem_op, load_op, misaligned, go;
  logic [3:0]        lane_sel;
  logic [RegBus-1:0] lane_wdata, lane_load, load_data_q;

  assign mem_op  = is_mem_op(mem_aluop);
  assign load_op = is_load_op(mem_aluop);

`ifdef MEM_ALIGN_CHK_EN
  always_comb begin
    misaligned = 1'b0;
    case (mem_aluop)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misaligned = mem_mem_addr[0];
      EXE_LW_OP, EXE_SW_OP:             misaligned = |mem_mem_addr[1:0];
      default: ;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign go        = mem_op & ~misaligned;
  assign align_exc = ~rst & misaligned;

  mem_lane_align u_lane (
    .aluop    (mem_aluop),
    .addr_lo  (mem_mem_addr[1:0]),
    .reg2     (mem_reg2),
    .rdata    (dbus_rdata),
    .sel      (lane_sel),
    .wdata    (lane_wdata),
    .load_data(lane_load)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (go) state_nxt = ST_BUSY;
      ST_BUSY: if (dbus_ack) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign stallreq = ~rst & (((state == ST_IDLE) & go) | (state == ST_BUSY));
  assign wb_wd    = mem_wd;
  assign wb_wreg  = mem_wreg & ~align_exc;
  assign wb_wdata = load_op ? load_data_q : mem_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      dbus_req    <= 1'b0;
      dbus_we     <= 1'b0;
      dbus_addr   <= ZeroWord;
      dbus_sel    <= 4'b0000;
      dbus_wdata  <= ZeroWord;
      load_data_q <= ZeroWord;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (go) begin
          dbus_req   <= 1'b1;
          dbus_we    <= ~load_op;
          dbus_addr  <= {mem_mem_addr[RegBus-1:2], 2'b00};
          dbus_sel   <= lane_sel;
          dbus_wdata <= lane_wdata;
        end
        ST_BUSY: if (dbus_ack) begin
          dbus_req <= 1'b0;
          dbus_we  <= 1'b0;
          if (load_op) load_data_q <= lane_load;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl; expectations are hand-computed constants.
// Build with MEM_ALIGN_CHK_EN defined to exercise the misalignment trap.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [4:0]  wb_wd;
  logic        wb_wreg, stallreq, align_exc, dbus_req, dbus_we, dbus_ack;
  logic [31:0] wb_wdata, dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_sel;

  int passed = 0;
  int total  = 0;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .stallreq(stallreq), .align_exc(align_exc),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );

  always #5 clk = ~clk;

  // Drives one memory op, acks after 'waits' extra BUSY cycles, and reports what it saw.
  task automatic do_mem_op(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] reg2, input logic [31:0] rdata,
                           input int waits, output int stall_cnt,
                           output logic [3:0] sel, output logic [31:0] wdata,
                           output logic we, output logic [31:0] baddr,
                           output logic [31:0] wb, output bit unstable,
                           output bit align_seen, output bit timeout);
    int  busy_n;
    bit  done;
    busy_n = 0; done = 1'b0; stall_cnt = 0; unstable = 1'b0; align_seen = 1'b0;
    sel = 4'h0; wdata = 32'h0; we = 1'b0; baddr = 32'h0; wb = 32'h0;
    @(posedge clk); #1;
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2; mem_wdata = 32'h0;
    mem_wreg = 1'b1; mem_wd = 5'd3; dbus_rdata = rdata;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (align_exc) align_seen = 1'b1;
      if (stallreq) stall_cnt++;
      if (dbus_req) begin
        busy_n++;
        if (busy_n == 1) begin
          sel = dbus_sel; wdata = dbus_wdata; we = dbus_we; baddr = dbus_addr;
        end else if (sel !== dbus_sel || wdata !== dbus_wdata || we !== dbus_we || baddr !== dbus_addr)
          unstable = 1'b1;
        if (busy_n == waits + 1) dbus_ack = 1'b1;
      end else if (stall_cnt > 0 && !stallreq) begin
        wb = wb_wdata;
        done = 1'b1;
      end
      @(posedge clk); #1;
      dbus_ack = 1'b0;
    end
    mem_aluop = EXE_NOP_OP; mem_wreg = 1'b0;
    timeout = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    mem_aluop = EXE_ADD_OP; mem_wdata = 32'h55; mem_wd = 5'd9; mem_wreg = 1'b1;
    mem_mem_addr = 32'h10; mem_reg2 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (stallreq !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stallreq); else passed++;
    total++; if (align_exc !== 1'b0) $display("FAIL reset_align: got %b expected 0", align_exc); else passed++;
    total++; if ({dbus_req, dbus_we, dbus_sel} !== 6'b0) $display("FAIL reset_bus_ctl: got %b expected 000000", {dbus_req, dbus_we, dbus_sel}); else passed++;
    total++; if ({dbus_addr, dbus_wdata} !== 64'h0) $display("FAIL reset_bus_data: got %h expected 0", {dbus_addr, dbus_wdata}); else passed++;
    total++; if ({wb_wd, wb_wreg, wb_wdata} !== {5'd9, 1'b1, 32'h55}) $display("FAIL reset_wb_pass: got %h expected %h", {wb_wd, wb_wreg, wb_wdata}, {5'd9, 1'b1, 32'h55}); else passed++;
    mem_aluop = EXE_LW_OP; #1;
    total++; if (stallreq !== 1'b0) $display("FAIL reset_lw_stall: got %b expected 0", stallreq); else passed++;
    total++; if (wb_wdata !== 32'h0) $display("FAIL reset_load_reg: got %h expected 0", wb_wdata); else passed++;
    mem_aluop = EXE_NOP_OP; mem_wreg = 1'b0;
    @(negedge clk); rst = 1'b0;
    // ack while idle must not launch or complete anything
    repeat (2) @(negedge clk);
    total++; if ({dbus_req, stallreq} !== 2'b00) $display("FAIL idle_ack_ignored: got %b expected 00", {dbus_req, stallreq}); else passed++;
    dbus_ack = 1'b0;
  endtask

  task automatic test_lw();
    int sc; logic [3:0] s; logic [31:0] wd, ba, wb; logic we; bit un, al, to;
    do_mem_op(EXE_LW_OP, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, sc, s, wd, we, ba, wb, un, al, to);
    total++; if (to) $display("FAIL lw_timeout: got timeout expected completion"); else passed++;
    total++; if (s !== 4'b1111) $display("FAIL lw_sel: got %b expected 1111", s); else passed++;
    total++; if ({we, ba} !== {1'b0, 32'h10}) $display("FAIL lw_we_addr: got %h expected %h", {we, ba}, {1'b0, 32'h10}); else passed++;
    total++; if (sc != 2) $display("FAIL lw_stall_cycles: got %0d expected 2", sc); else passed++;
    total++; if (wb !== 32'hDEAD_BEEF) $display("FAIL lw_wb_wdata: got %h expected deadbeef", wb); else passed++;
  endtask

  task automatic test_loads_ext();
    int sc; logic [3:0] s; logic [31:0] wd, ba, wb; logic we; bit un, al, to;
    do_mem_op(EXE_LB_OP, 32'h0000_0003, 32'h0, 32'h0000_00F0, 0, sc, s, wd, we, ba, wb, un, al, to);
    total++; if ({s, wb} !== {4'b0001, 32'hFFFF_FFF0} || to) $display("FAIL lb: got sel %b data %h expected 0001 fffffff0", s, wb); else passed++;
    do_mem_op(EXE_LBU_OP, 32'h0000_0003, 32'h0, 32'h0000_00F0, 1, sc, s, wd, we, ba, wb, un, al, to);
    total++; if ({s, wb} !== {4'b0001, 32'h0000_00F0} || to) $display("FAIL lbu: got sel %b data %h expected 0001 000000f0", s, wb); else passed++;
    total++; if (sc != 3) $display("FAIL lbu_stall_cycles: got %0d expected 3", sc); else passed++;
    do_mem_op(EXE_LB_OP, 32'h0000_0000, 32'h0, 32'h7F80_0000, 0, sc, s, wd, we, ba, wb, un, al, to);
    total++; if ({s, wb} !== {4'b1000, 32'h0000_007F} || to) $display("FAIL lb_lane0: got sel %b data %h expected 1000 0000007f", s, wb); else passed++;
    do_mem_op(EXE_LH_OP, 32'h0000_0020, 32'h0, 32'h8001_1234, 0, sc, s, wd, we, ba, wb, un, al, to);
    total++; if ({s, wb} !== {4'b1100, 32'hFFFF_8001} || to) $display("FAIL lh: got sel %b data %h expected 1100 ffff8001", s, wb); else passed++;
    do_mem_op(EXE_LHU_OP, 32'h0000_0022, 32'h0, 32'h1234_8001, 0, sc, s, wd, we, ba, wb, un, al, to);
    total++; if ({s, wb, ba} !== {4'b0011, 32'h0000_8001, 32'h20} || to) $display("FAIL lhu: got sel %b data %h addr %h expected 0011 00008001 00000020", s, wb, ba); else passed++;
  endtask

  task automatic test_stores();
    int sc; logic [3:0] s; logic [31:0] wd, ba, wb; logic we; bit un, al, to;
    do_mem_op(EXE_SH_OP, 32'h0000_0002, 32'h1234_ABCD, 32'h0, 3, sc, s, wd, we, ba, wb, un, al, to);
    total++; if (to) $display("FAIL sh_timeout: got timeout expected completion"); else passed++;
    total++; if ({s, we} !== {4'b0011, 1'b1}) $display("FAIL sh_sel_we: got %b expected 00111", {s, we}); else passed++;
    total++; if (wd !== 32'hABCD_ABCD) $display("FAIL sh_wdata: got %h expected abcdabcd", wd); else passed++;
    total++; if (ba !== 32'h0) $display("FAIL sh_addr: got %h expected 00000000", ba); else passed++;
    total++; if (sc != 5) $display("FAIL sh_stall_cycles: got %0d expected 5", sc); else passed++;
    total++; if (un) $display("FAIL sh_bus_stable: got changing outputs expected stable"); else passed++;
    do_mem_op(EXE_SB_OP, 32'h0000_0101, 32'hAAAA_AA77, 32'h0, 0, sc, s, wd, we, ba, wb, un, al, to);
    total++; if ({s, we, wd, ba} !== {4'b0100, 1'b1, 32'h7777_7777, 32'h100} || to) $display("FAIL sb: got %b %b %h %h expected 0100 1 77777777 00000100", s, we, wd, ba); else passed++;
    do_mem_op(EXE_SW_OP, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 2, sc, s, wd, we, ba, wb, un, al, to);
    total++; if ({s, we, wd, ba} !== {4'b1111, 1'b1, 32'hCAFE_F00D, 32'h40} || to || un) $display("FAIL sw: got %b %b %h %h expected 1111 1 cafef00d 00000040", s, we, wd, ba); else passed++;
  endtask

  task automatic test_passthrough();
    @(posedge clk); #1;
    mem_aluop = EXE_ADD_OP; mem_wdata = 32'h5; mem_wd = 5'd7; mem_wreg = 1'b1; #1;
    total++; if ({stallreq, wb_wdata} !== {1'b0, 32'h5}) $display("FAIL add_same_cycle: got %h expected %h", {stallreq, wb_wdata}, {1'b0, 32'h5}); else passed++;
    total++; if ({wb_wd, wb_wreg} !== {5'd7, 1'b1}) $display("FAIL add_wb_ctl: got %h expected %h", {wb_wd, wb_wreg}, {5'd7, 1'b1}); else passed++;
    repeat (2) @(negedge clk);
    total++; if ({dbus_req, stallreq} !== 2'b00) $display("FAIL add_no_bus: got %b expected 00", {dbus_req, stallreq}); else passed++;
    mem_aluop = EXE_NOP_OP; mem_wreg = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int sc; logic [3:0] s; logic [31:0] wd, ba, wb; logic we; bit un, al, to;
    @(posedge clk); #1;
    mem_aluop = EXE_LB_OP; mem_mem_addr = 32'h0000_0031; mem_wreg = 1'b1; mem_wd = 5'd4;
    @(negedge clk);
    @(negedge clk);
    total++; if ({dbus_req, stallreq} !== 2'b11) $display("FAIL busy_before_rst: got %b expected 11", {dbus_req, stallreq}); else passed++;
    #1 rst = 1'b1; #1;
    total++; if ({dbus_req, dbus_sel, dbus_addr} !== 37'h0) $display("FAIL rst_mid_busy_bus: got %h expected 0", {dbus_req, dbus_sel, dbus_addr}); else passed++;
    total++; if ({stallreq, align_exc, wb_wdata} !== 34'h0) $display("FAIL rst_mid_busy_out: got %h expected 0", {stallreq, align_exc, wb_wdata}); else passed++;
    mem_aluop = EXE_NOP_OP; mem_wreg = 1'b0;
    @(negedge clk); rst = 1'b0; dbus_ack = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({dbus_req, stallreq} !== 2'b00) $display("FAIL late_ack_ignored: got %b expected 00", {dbus_req, stallreq}); else passed++;
    dbus_ack = 1'b0;
    do_mem_op(EXE_LW_OP, 32'h0000_0080, 32'h0, 32'h0102_0304, 0, sc, s, wd, we, ba, wb, un, al, to);
    total++; if (sc != 2 || wb !== 32'h0102_0304 || to) $display("FAIL after_rst_lw: got stalls %0d data %h expected 2 01020304", sc, wb); else passed++;
  endtask

  task automatic test_misaligned();
`ifdef MEM_ALIGN_CHK_EN
    @(posedge clk); #1;
    mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h0000_0006; mem_wreg = 1'b1; #1;
    total++; if ({align_exc, wb_wreg, stallreq} !== 3'b100) $display("FAIL mis_lw_flags: got %b expected 100", {align_exc, wb_wreg, stallreq}); else passed++;
    repeat (2) @(negedge clk);
    total++; if (dbus_req !== 1'b0) $display("FAIL mis_lw_no_req: got %b expected 0", dbus_req); else passed++;
    mem_aluop = EXE_SH_OP; mem_mem_addr = 32'h0000_0003; #1;
    total++; if ({align_exc, stallreq} !== 2'b10) $display("FAIL mis_sh_flags: got %b expected 10", {align_exc, stallreq}); else passed++;
    mem_aluop = EXE_NOP_OP; mem_wreg = 1'b0;
`else
    int sc; logic [3:0] s; logic [31:0] wd, ba, wb; logic we; bit un, al, to;
    do_mem_op(EXE_LW_OP, 32'h0000_0006, 32'h0, 32'h0BAD_F00D, 0, sc, s, wd, we, ba, wb, un, al, to);
    total++; if ({s, ba} !== {4'b1111, 32'h4} || to) $display("FAIL unaligned_lw_access: got sel %b addr %h expected 1111 00000004", s, ba); else passed++;
    total++; if (al || sc != 2) $display("FAIL unaligned_lw_no_trap: got align %b stalls %0d expected 0 2", al, sc); else passed++;
    do_mem_op(EXE_LHU_OP, 32'h0000_0003, 32'h0, 32'hAAAA_BEEF, 0, sc, s, wd, we, ba, wb, un, al, to);
    total++; if ({s, wb} !== {4'b0011, 32'h0000_BEEF} || al || to) $display("FAIL unaligned_lhu: got sel %b data %h expected 0011 0000beef", s, wb); else passed++;
`endif
  endtask

  initial begin
    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    mem_aluop = EXE_NOP_OP; mem_wd = 5'd0; mem_wreg = 1'b0;
    mem_wdata = 32'h0; mem_mem_addr = 32'h0; mem_reg2 = 32'h0;
    test_reset();
    test_lw();
    test_loads_ext();
    test_stores();
    test_passthrough();
    test_reset_mid_busy();
    test_misaligned();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
